// File: rtl/pipe_pkg.sv
// Shared EX/MEM field positions for the wb and m control vectors.
// Pure constants: no latency, no flow control.
package pipe_pkg;
    localparam int WB_MEMTOREG = 1;
    localparam int WB_REGWRITE = 0;
    localparam int M_MEMWRITE  = 2;
    localparam int M_MEMREAD   = 1;
    localparam int M_BRANCH    = 0;
    localparam int WB_W        = 2;
    localparam int M_W         = 3;

    // Packed payload width for a given geometry: {pc, wb, m, zero, alu, rt, writereg}.
    function automatic int ex_mem_w(input int pc_w, input int data_w, input int reg_aw);
        return pc_w + WB_W + M_W + 1 + 2 * data_w + reg_aw;
    endfunction
endpackage

// File: rtl/pipe_skid_slot.sv
// One payload register with a valid bit; load wins over clear, payload kept on clear.
// Latency 1 cycle from load to q; no backpressure of its own, the owner decides when to load.
module pipe_skid_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic         vld,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= 1'b0;
            q   <= '0;
        end else if (load) begin
            vld <= 1'b1;
            q   <= d;
        end else if (clear) begin
            vld <= 1'b0;
        end
    end
endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM boundary register: 1-cycle latency, valid/ready with stall (ce) and flush.
// SKID=1 keeps a second entry so in_ready is registered; SKID=0 gives combinational in_ready.
module ex_mem_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int REG_AW = 5,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ce,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   pc,
    input  logic [1:0]        wb,
    input  logic [2:0]        m,
    input  logic              zero,
    input  logic [DATA_W-1:0] alu_in,
    input  logic [DATA_W-1:0] readreg_rt,
    input  logic [REG_AW-1:0] writereg,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   pc_out,
    output logic [1:0]        wb_out,
    output logic              memwrite,
    output logic              memread,
    output logic              branch,
    output logic              zero_out,
    output logic              branch_taken,
    output logic [DATA_W-1:0] alu_out,
    output logic [DATA_W-1:0] readreg_rt_out,
    output logic [REG_AW-1:0] writereg_out,
    output logic              fwd_regwrite,
    output logic [REG_AW-1:0] fwd_writereg,
    output logic [DATA_W-1:0] fwd_data
);
    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [WB_W-1:0]   wb;
        logic [M_W-1:0]    m;
        logic              zero;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] rt;
        logic [REG_AW-1:0] writereg;
    } ex_mem_t;

    localparam int PW = ex_mem_w(PC_W, DATA_W, REG_AW);

    ex_mem_t        in_ent;
    ex_mem_t        head;
    logic [PW-1:0]  main_d;
    logic [PW-1:0]  main_q;
    logic           main_vld;
    logic           main_load;
    logic           main_clear;
    logic           accept;
    logic           drain;

    assign in_ent = '{pc: pc, wb: wb, m: m, zero: zero, alu: alu_in,
                      rt: readreg_rt, writereg: writereg};

    assign accept     = in_valid & in_ready & ce & ~flush;
    assign drain      = main_vld & out_ready & ce;
    assign main_clear = flush | drain;

    generate
        if (SKID != 0) begin : g_skid
            logic          skid_vld;
            logic          skid_load;
            logic [PW-1:0] skid_q;

            // in_ready comes straight off the skid valid flop, so it never sees out_ready.
            assign in_ready  = ~skid_vld;
            assign skid_load = accept & main_vld & ~drain;
            assign main_load = ~flush & ((drain & skid_vld) | (accept & (~main_vld | drain)));
            assign main_d    = skid_vld ? skid_q : PW'(in_ent);

            pipe_skid_slot #(.W(PW)) u_skid (
                .clk   (clk),
                .rst_n (rst_n),
                .load  (skid_load),
                .clear (main_clear),
                .d     (PW'(in_ent)),
                .vld   (skid_vld),
                .q     (skid_q)
            );
        end else begin : g_single
            assign in_ready  = ~main_vld | (out_ready & ce);
            assign main_load = accept;
            assign main_d    = PW'(in_ent);
        end
    endgenerate

    pipe_skid_slot #(.W(PW)) u_main (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (main_load),
        .clear (main_clear),
        .d     (main_d),
        .vld   (main_vld),
        .q     (main_q)
    );

    assign head      = ex_mem_t'(main_q);
    assign out_valid = main_vld;

    // Control outputs of an empty slot read as a bubble; data is left ungated.
    assign pc_out         = head.pc;
    assign wb_out         = out_valid ? head.wb : 2'b00;
    assign memwrite       = out_valid & head.m[M_MEMWRITE];
    assign memread        = out_valid & head.m[M_MEMREAD];
    assign branch         = out_valid & head.m[M_BRANCH];
    assign zero_out       = head.zero;
    assign branch_taken   = branch & zero_out;
    assign alu_out        = head.alu;
    assign readreg_rt_out = head.rt;
    assign writereg_out   = head.writereg;
    assign fwd_regwrite   = wb_out[WB_REGWRITE];
    assign fwd_writereg   = writereg_out;
    assign fwd_data       = alu_out;
endmodule
